fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Instruction-fetch front end between the instruction memory port and the IF/ID pipeline register. It replaces the single-cycle combinational fetch with a request/response memory interface and an in-order prefetch FIFO. It keeps issuing sequential fetches while the decode stage is held, and it flushes cleanly when a taken branch redirects the PC. Consumers see a valid/hold interface carrying the instruction word and its PC+4.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `MAX_OUT`, 2: maximum outstanding memory requests, 1..3.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `redirect`  input  1  taken branch; flush queue and refetch from `redirect_pc`.
- `redirect_pc`  input  32  branch target; word-aligned.
- `mem_req`  output  1  fetch request valid.
- `mem_addr`  output  32  fetch address, equal to `fetch_pc`.
- `mem_ready`  input  1  memory accepts the request this cycle.
- `mem_rvalid`  input  1  response valid; responses return in request order, latency ≥1 cycle.
- `mem_rdata`  input  32  instruction word.
- `out_valid`  output  1  head entry valid.
- `out_instr`  output  32  head instruction.
- `out_pc_plus_four`  output  32  head PC + 4.
- `hold`  input  1  decode stall from the hazard detection unit; head is not consumed.
- `count`  output  log2(DEPTH)+1  FIFO occupancy.

## Operation
- State: `fetch_pc`, FIFO (instr and pc_plus_four per entry), `inflight` (0..MAX_OUT), `drop` (0..inflight), and a pending-PC FIFO of depth MAX_OUT that holds each outstanding request's address.
- Issue: `mem_req` = !reset && !redirect && inflight < MAX_OUT && count + (inflight − drop) < DEPTH. All terms use registered values; a pop in the same cycle gives no credit.
- Accept (`mem_req && mem_ready`): push `fetch_pc` to the pending-PC FIFO, `inflight`+1, `fetch_pc` += 4 (32-bit wrap, 0xFFFF_FFFC → 0).
- Response (`mem_rvalid`): `inflight`−1 and pop the pending PC.
  - If `drop` > 0: discard and decrement `drop`.
  - Otherwise: push {mem_rdata, pending_pc + 4} into the FIFO.
  - `mem_rvalid` with `inflight` = 0 is illegal and is ignored.
- Pop: when `out_valid && !hold`. Push and pop in the same cycle are both performed and `count` is unchanged. Space reservation guarantees a non-dropped response never arrives while the FIFO is full.
- `out_valid` = (count != 0). `out_instr` and `out_pc_plus_four` show the head entry and are 0 when empty.
- Redirect (highest priority after reset):
  - FIFO is cleared (`count` ← 0); any response in this cycle is discarded.
  - `drop` ← `inflight` − `mem_rvalid`; `inflight` ← `inflight` − `mem_rvalid`.
  - `fetch_pc` ← `redirect_pc`; `mem_req` is low this cycle.
  - `hold` is ignored in this cycle.
- Redirect while `drop` > 0 recomputes `drop` as above; every outstanding request is dropped.

## Timing
- Reset, effective at the next edge: `fetch_pc` = RESET_PC; `count`, `inflight`, `drop` = 0; `out_valid` = 0; `out_instr` = 0; `out_pc_plus_four` = 0. `mem_req` is 0 while reset is high.
- Reset mid-operation abandons outstanding requests. The memory must also be reset, so no stale `mem_rvalid` arrives after reset.
- Latency with 1-cycle memory, starting from an empty queue:
  - request accepted in cycle N;
  - `mem_rvalid` in N+1;
  - `out_valid` in N+2.
- Sustained throughput is 1 instruction/cycle when `mem_ready` = 1, latency = 1, `hold` = 0, and MAX_OUT ≥ 2.
- Redirect in cycle R: first request to `redirect_pc` in R+1. With 1-cycle memory its instruction reaches `out_valid` in R+3.

## Test plan
- Reset then free run (memory latency 1, `mem_ready`=1, word = address): `mem_addr` 0,4,8,… on consecutive cycles. Outputs appear in order with `out_pc_plus_four` = addr+4. `out_valid` first rises 2 cycles after the first accept.
- Hold for 10 cycles, DEPTH=4: `count` saturates at 4 and `mem_req` drops once count + (inflight − drop) = 4. The head stays at the same entry. Releasing `hold` drains 1 entry per cycle with no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding (latency 3): both late responses are discarded. The next `out_instr` is the word at 0x100 with `out_pc_plus_four` 0x104.
- Redirect in the same cycle as `mem_rvalid` and `hold`=1: that response and the FIFO are discarded, `count`=0 next cycle, `drop` = inflight−1.
- Back-to-back redirects (0x200, then 0x300 the next cycle): nothing from 0x200 is ever output. The first output is from 0x300.
- Randomized `mem_ready`, `mem_rvalid` latency 1–5, and `hold`, checked against a reference model: output order exact, no overflow, `inflight` ≤ MAX_OUT, and `fetch_pc` wraps correctly from 0xFFFF_FFFC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues in-order memory requests, buffers responses in a
// prefetch FIFO, and flushes on branch redirect by dropping responses still in flight.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc_plus_four,
  input  logic                     hold,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [31:0]   fetch_pc;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   ppf_q   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [31:0]   pend_q  [MAX_OUT];
  logic [PW-1:0] pend_rd;
  logic [PW-1:0] pend_wr;

  logic          rsp;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   reserved;

  function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
  endfunction

  // A response with nothing outstanding is illegal and simply ignored.
  assign rsp      = mem_rvalid && (inflight != '0);
  // Entries already in the FIFO plus responses that will still be kept.
  assign reserved = 32'(count) + 32'(inflight) - 32'(drop);
  assign mem_req  = !reset && !redirect && (32'(inflight) < MAX_OUT) && (reserved < DEPTH);
  assign mem_addr = fetch_pc;
  assign accept   = mem_req && mem_ready;
  assign push     = rsp && (drop == '0) && !redirect;
  assign pop      = out_valid && !hold && !redirect;

  assign out_valid        = (count != '0);
  assign out_instr        = out_valid ? instr_q[rd_ptr] : '0;
  assign out_pc_plus_four = out_valid ? ppf_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= '0;
      drop     <= '0;
      pend_rd  <= '0;
      pend_wr  <= '0;
    end else begin
      if (rsp)    pend_rd <= pend_inc(pend_rd);
      if (accept) pend_wr <= pend_inc(pend_wr);
      if (redirect) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        inflight <= inflight - IW'(rsp);
        drop     <= inflight - IW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        inflight <= inflight + IW'(accept) - IW'(rsp);
        if (rsp && (drop != '0)) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_rdata;
      ppf_q[wr_ptr]   <= pend_q[pend_rd] + 32'd4;
    end
    if (accept) pend_q[pend_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order variable-latency memory model
// whose instruction word is the bitwise inverse of its address.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus_four;
  logic        hold;
  logic [2:0]  count;

  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  int          consumed;
  int          c_start;
  logic [31:0] exp_next;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  fetch_prefetch_queue #(
    .DEPTH(4),
    .MAX_OUT(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc_plus_four(out_pc_plus_four),
    .hold(hold),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (q_addr.size() != 0 && q_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ~q_addr[0];
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
  endtask

  // One clock: sample mid-cycle, score consumed heads, then advance the memory model.
  task automatic tick();
    logic        acc;
    logic        rsp;
    logic        rst_s;
    logic [31:0] a;
    @(negedge clk);
    acc   = mem_req && mem_ready;
    a     = mem_addr;
    rsp   = mem_rvalid;
    rst_s = reset;
    if (!rst_s && out_valid && !hold && !redirect) begin
      checks++;
      assert (out_instr === ~exp_next && out_pc_plus_four === exp_next + 32'd4) else begin
        errors++;
        $error("FAIL stream: observed instr %h pc4 %h expected instr %h pc4 %h",
               out_instr, out_pc_plus_four, ~exp_next, exp_next + 32'd4);
      end
      exp_next = exp_next + 32'd4;
      consumed++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (rsp) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (acc) begin
        q_addr.push_back(a);
        q_due.push_back(cyc - 1 + lat);
      end
    end
    drive_mem();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    hold     = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    consumed    = 0;
    lat         = 1;
    exp_next    = 32'h0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    hold        = 1'b0;
    mem_ready   = 1'b1;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;

    // Reset, then free run at latency 1.
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc4", out_pc_plus_four, 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    exp_next = 32'h0;
    #1;
    check("run_first_req", 32'(mem_req), 32'd1);
    check("run_first_addr", mem_addr, 32'h0);
    tick();
    check("run_c1_valid", 32'(out_valid), 32'd0);
    check("run_c1_addr", mem_addr, 32'h4);
    tick();
    check("run_c2_valid", 32'(out_valid), 32'd1);
    check("run_c2_instr", out_instr, ~32'h0);
    check("run_c2_pc4", out_pc_plus_four, 32'h4);
    for (int i = 0; i < 6; i++) begin
      check("run_seq_addr", mem_addr, 32'(8 + 4 * i));
      check("run_seq_req", 32'(mem_req), 32'd1);
      tick();
    end
    check("run_count", 32'(count), 32'd1);
    check("run_head_pc4", out_pc_plus_four, 32'd28);

    // Hold for 10 cycles: FIFO fills, requests stop, head stays put.
    hold = 1'b1;
    tick();
    check("hold_c9_req", 32'(mem_req), 32'd1);
    tick();
    check("hold_c10_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("hold_count", 32'(count), 32'd4);
    check("hold_req", 32'(mem_req), 32'd0);
    check("hold_head_instr", out_instr, ~32'd24);
    check("hold_head_pc4", out_pc_plus_four, 32'd28);
    check("hold_fetch_addr", mem_addr, 32'd40);
    hold = 1'b0;
    tick();
    check("drain_count3", 32'(count), 32'd3);
    tick();
    check("drain_count2", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) tick();

    // Redirect to 0x100 with two requests outstanding at latency 3.
    do_reset();
    lat = 3;
    reset = 1'b0;
    exp_next = 32'h0;
    tick();
    tick();
    check("rd1_full_req", 32'(mem_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    exp_next = 32'h100;
    #1;
    check("rd1_req_low", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("rd1_count", 32'(count), 32'd0);
    check("rd1_busy_req", 32'(mem_req), 32'd0);
    check("rd1_addr", mem_addr, 32'h100);
    tick();
    check("rd1_new_req", 32'(mem_req), 32'd1);
    check("rd1_new_addr", mem_addr, 32'h100);
    check("rd1_c4_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd1_wait_valid", 32'(out_valid), 32'd0);
    end
    tick();
    check("rd1_out_valid", 32'(out_valid), 32'd1);
    check("rd1_out_instr", out_instr, ~32'h100);
    check("rd1_out_pc4", out_pc_plus_four, 32'h104);
    for (int i = 0; i < 8; i++) tick();

    // Redirect coinciding with a response while hold is high.
    do_reset();
    lat = 2;
    hold = 1'b1;
    reset = 1'b0;
    exp_next = 32'h0;
    for (int i = 0; i < 5; i++) tick();
    check("rd2_pre_count", 32'(count), 32'd2);
    check("rd2_pre_head", out_instr, ~32'h0);
    check("rd2_pre_rvalid", 32'(mem_rvalid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    exp_next = 32'h40;
    tick();
    redirect = 1'b0;
    #1;
    check("rd2_count", 32'(count), 32'd0);
    check("rd2_valid", 32'(out_valid), 32'd0);
    check("rd2_instr", out_instr, 32'h0);
    check("rd2_req", 32'(mem_req), 32'd1);
    check("rd2_addr", mem_addr, 32'h40);
    hold = 1'b0;
    tick();
    check("rd2_c7_valid", 32'(out_valid), 32'd0);
    tick();
    check("rd2_c8_valid", 32'(out_valid), 32'd0);
    tick();
    check("rd2_out_valid", 32'(out_valid), 32'd1);
    check("rd2_out_instr", out_instr, ~32'h40);
    check("rd2_out_pc4", out_pc_plus_four, 32'h44);
    for (int i = 0; i < 6; i++) tick();

    // Back-to-back redirects to 0x200 then 0x300.
    do_reset();
    lat = 2;
    reset = 1'b0;
    exp_next = 32'h0;
    #1;
    check("rd3_first_addr", mem_addr, 32'h0);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    exp_next = 32'h200;
    tick();
    redirect_pc = 32'h300;
    exp_next = 32'h300;
    tick();
    redirect = 1'b0;
    #1;
    check("rd3_req", 32'(mem_req), 32'd1);
    check("rd3_addr", mem_addr, 32'h300);
    check("rd3_c3_valid", 32'(out_valid), 32'd0);
    tick();
    check("rd3_c4_valid", 32'(out_valid), 32'd0);
    tick();
    check("rd3_c5_valid", 32'(out_valid), 32'd0);
    tick();
    check("rd3_out_valid", 32'(out_valid), 32'd1);
    check("rd3_out_instr", out_instr, ~32'h300);
    for (int i = 0; i < 6; i++) tick();

    // Address wrap from 0xFFFF_FFFC to 0.
    do_reset();
    lat = 1;
    reset = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_next = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_addr1", mem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr2", mem_addr, 32'h0);
    check("wrap_head_pc4", out_pc_plus_four, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc4_zero", out_pc_plus_four, 32'h0);
    check("wrap_instr", out_instr, 32'h3);
    for (int i = 0; i < 4; i++) tick();

    // Mixed ready, latency and hold patterns; the stream scorer checks ordering.
    do_reset();
    reset = 1'b0;
    exp_next = 32'h0;
    c_start = consumed;
    for (int i = 0; i < 48; i++) begin
      mem_ready = ((i % 3) != 2);
      hold      = ((i % 5) == 1) || ((i % 7) == 3);
      lat       = 1 + (i % 5);
      tick();
    end
    mem_ready = 1'b1;
    hold = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) tick();
    check("mix_progress", 32'(consumed > c_start + 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
